// File: rtl/clk_switch_pkg.sv
// Shared types and helpers for the glitch-free divided-clock switch.
package clk_switch_pkg;

    typedef enum logic [1:0] {
        RUN_A = 2'd0,
        IDLE  = 2'd1,
        RUN_B = 2'd2
    } sw_state_t;

    function automatic int unsigned half(input int unsigned div);
        return div / 2;
    endfunction

endpackage

// File: rtl/clk_switch_sync_clk_div.sv
// Free-running 0..DIV-1 counter with a 50% phase, fall/wrap strobes and a load port.
module clk_div_cnt
    import clk_switch_pkg::*;
#(
    parameter int unsigned DIV = 2,
    parameter int unsigned W   = (DIV > 2) ? $clog2(DIV) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         force_en,
    input  logic [W-1:0] force_val,
    output logic [W-1:0] cnt,
    output logic         ph,
    output logic         fall,
    output logic         wrap
);

    localparam logic [W-1:0] LAST_V = W'(DIV - 1);
    localparam logic [W-1:0] HALF_V = W'(half(DIV));

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST_V) ? '0 : cnt_q + W'(1);
        if (force_en) begin
            cnt_d = force_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign ph   = (cnt_q < HALF_V);
    assign fall = (cnt_q == HALF_V);
    assign wrap = (cnt_q == '0);

endmodule

// File: rtl/clk_switch_sync.sv
// Break-before-make switch between two divided clocks of one master clock.
// Define CLK_SWITCH_SEL_SYNC_EN to pass sel through a 2-flop synchronizer.
module clk_switch_sync
    import clk_switch_pkg::*;
#(
    parameter int unsigned DIV_A = 20,
    parameter int unsigned DIV_B = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic sel,
    output logic clk_out,
    output logic sel_ack,
    output logic busy
);

    localparam int unsigned WA = (DIV_A > 2) ? $clog2(DIV_A) : 1;
    localparam int unsigned WB = (DIV_B > 2) ? $clog2(DIV_B) : 1;
    // The exit edge itself plays the role of the target's first low cycle,
    // so the target resumes one count past the start of its low phase.
    localparam logic [WA-1:0] FORCE_A = WA'((half(DIV_A) + 1) % DIV_A);
    localparam logic [WB-1:0] FORCE_B = WB'((half(DIV_B) + 1) % DIV_B);

    logic sel_s_q, sel_s_d;
`ifdef CLK_SWITCH_SEL_SYNC_EN
    logic sel_meta_q, sel_meta_d;
    always_comb begin
        sel_meta_d = sel;
        sel_s_d    = sel_meta_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_meta_q <= 1'b0;
            sel_s_q    <= 1'b0;
        end else begin
            sel_meta_q <= sel_meta_d;
            sel_s_q    <= sel_s_d;
        end
    end
`else
    always_comb sel_s_d = sel;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_s_q <= 1'b0;
        end else begin
            sel_s_q <= sel_s_d;
        end
    end
`endif

    logic [WA-1:0] cnt_a;
    logic [WB-1:0] cnt_b;
    logic          ph_a, fall_a, wrap_a, force_a;
    logic          ph_b, fall_b, wrap_b, force_b;

    clk_div_cnt #(.DIV(DIV_A), .W(WA)) u_div_a (
        .clk(clk), .rst(rst), .force_en(force_a), .force_val(FORCE_A),
        .cnt(cnt_a), .ph(ph_a), .fall(fall_a), .wrap(wrap_a)
    );

    clk_div_cnt #(.DIV(DIV_B), .W(WB)) u_div_b (
        .clk(clk), .rst(rst), .force_en(force_b), .force_val(FORCE_B),
        .cnt(cnt_b), .ph(ph_b), .fall(fall_b), .wrap(wrap_b)
    );

    // Raw counts are only of interest when probing the block.
    logic unused_cnt;
    assign unused_cnt = ^{cnt_a, cnt_b};

    sw_state_t state_q, state_d;
    logic      clk_out_q, clk_out_d;
    logic      sel_ack_q, sel_ack_d;
    logic      busy_q, busy_d;
    logic      req;

    always_comb begin
        state_d   = state_q;
        clk_out_d = 1'b0;
        sel_ack_d = sel_ack_q;
        busy_d    = busy_q;
        force_a   = 1'b0;
        force_b   = 1'b0;
        req       = (sel_s_q != sel_ack_q);
        case (state_q)
            RUN_A: begin
                clk_out_d = ph_a;
                busy_d    = 1'b0;
                if (req && fall_a) begin
                    state_d   = IDLE;
                    busy_d    = 1'b1;
                    force_b   = 1'b1;
                    clk_out_d = 1'b0;
                end
            end
            RUN_B: begin
                clk_out_d = ph_b;
                busy_d    = 1'b0;
                if (req && fall_b) begin
                    state_d   = IDLE;
                    busy_d    = 1'b1;
                    force_a   = 1'b1;
                    clk_out_d = 1'b0;
                end
            end
            IDLE: begin
                // Target is the source not currently acknowledged.
                if (sel_ack_q ? wrap_a : wrap_b) begin
                    sel_ack_d = ~sel_ack_q;
                    state_d   = sel_ack_q ? RUN_A : RUN_B;
                    busy_d    = 1'b0;
                    clk_out_d = 1'b1;
                end
            end
            default: begin
                state_d = RUN_A;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN_A;
            clk_out_q <= 1'b0;
            sel_ack_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_out_q <= clk_out_d;
            sel_ack_q <= sel_ack_d;
            busy_q    <= busy_d;
        end
    end

    assign clk_out = clk_out_q;
    assign sel_ack = sel_ack_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_clk_switch_sync.sv
// Directed bench for clk_switch_sync: pulse-width scoreboard on clk_out plus status checks.
module tb_clk_switch_sync;

    localparam int HA = 10;
    localparam int HB = 3;
`ifdef CLK_SWITCH_SEL_SYNC_EN
    localparam int SLAT = 2;
`else
    localparam int SLAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sel = 1'b0;
    logic clk_out, sel_ack, busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Expected pulses: {level, width in master cycles}
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    clk_switch_sync #(.DIV_A(20), .DIV_B(6)) dut (
        .clk(clk), .rst(rst), .sel(sel),
        .clk_out(clk_out), .sel_ack(sel_ack), .busy(busy)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic push1(input logic lvl, input int w);
        logic [6:0] w7;
        w7 = 7'(w);
        exp_q.push_back({lvl, w7});
    endtask

    task automatic push_a(input int n);
        for (int i = 0; i < n; i++) begin
            push1(1'b1, HA);
            push1(1'b0, HA);
        end
    endtask

    task automatic push_b(input int n);
        for (int i = 0; i < n; i++) begin
            push1(1'b1, HB);
            push1(1'b0, HB);
        end
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic goto(input int n);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (cyc != n && guard < 5000);
        if (cyc != n) begin
            checks++;
            errors++;
            $display("FAIL goto: cyc %0d expected %0d", cyc, n);
        end
    endtask

    // Monitor: measures each completed clk_out pulse and pops the expected one.
    logic       cur_lvl = 1'b0;
    int         run_len = 0;
    bit         skip = 1'b1;
    logic [7:0] got_p, exp_p;

    always @(negedge clk) begin
        if (rst) begin
            cur_lvl = 1'b0;
            run_len = 0;
            skip    = 1'b1;
        end else if (clk_out === cur_lvl) begin
            run_len++;
        end else begin
            if (skip) begin
                skip = 1'b0;
            end else begin
                got_p = {cur_lvl, 7'(run_len)};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pulse: unexpected level %0b width %0d at cyc %0d",
                             cur_lvl, run_len, cyc);
                end else begin
                    exp_p = exp_q.pop_front();
                    if (got_p !== exp_p) begin
                        errors++;
                        $display("FAIL pulse: got level %0b width %0d expected level %0b width %0d at cyc %0d",
                                 got_p[7], got_p[6:0], exp_p[7], exp_p[6:0], cyc);
                    end
                end
            end
            cur_lvl = clk_out;
            run_len = 1;
        end
    end

    initial begin
        int g;
        #1 rst = 1'b1;
        repeat (100) @(negedge clk);
        check("rst_clk_out", clk_out, 1'b0);
        check("rst_sel_ack", sel_ack, 1'b0);
        check("rst_busy", busy, 1'b0);

        // Full expected pulse train up to the mid-switch reset.
        push_a(5); push1(1'b1, HA); push1(1'b0, HB);           // A, then A->B
        push_b(15); push1(1'b1, HB); push1(1'b0, HA);          // B, then B->A
        push_a(4); push1(1'b1, HA); push1(1'b0, HB);           // A->B with toggle back
        push1(1'b1, HB); push1(1'b0, HA);                      // one B period, B->A
        push_a(6); push1(1'b1, HA); push1(1'b0, HB);           // short pulse ignored, A->B at fall
        push_b(8); push1(1'b1, HB);                            // B until reset
        rst = 1'b0;

        goto(94);  sel = 1'b1;
        goto(112); check("a2b_busy", busy, 1'b1);
        goto(150); check("a2b_ack", sel_ack, 1'b1); check("a2b_done", busy, 1'b0);
        goto(201); sel = 1'b0;
        goto(210); check("b2a_busy", busy, 1'b1);
        goto(250); check("b2a_ack", sel_ack, 1'b0); check("b2a_done", busy, 1'b0);

        goto(299); sel = 1'b1;
        goto(307); sel = 1'b0;
        goto(316); check("toggle_busy", busy, 1'b1); check("toggle_ack", sel_ack, 1'b1);
        goto(350); check("toggle_ack_a", sel_ack, 1'b0); check("toggle_done", busy, 1'b0);

        goto(399); sel = 1'b1;
        goto(400); sel = 1'b0;
        goto(420); check("short_ack", sel_ack, 1'b0); check("short_busy", busy, 1'b0);

        goto(453 - SLAT - 1); sel = 1'b1;
        goto(480); check("edge_ack", sel_ack, 1'b1); check("edge_busy", busy, 1'b0);

        goto(501); sel = 1'b0;
        goto(510); check("pre_rst_busy", busy, 1'b1);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL seg1_drain: %0d pulses left expected 0", exp_q.size());
        end
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_clk_out", clk_out, 1'b0);
        check("async_sel_ack", sel_ack, 1'b0);
        check("async_busy", busy, 1'b0);
        push_a(3);
        repeat (5) @(negedge clk);
        rst = 1'b0;

        goto(50); check("restart_ack", sel_ack, 1'b0); check("restart_busy", busy, 1'b0);
        g = 0;
        while (exp_q.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL seg2_drain: %0d pulses left expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
